psum_glb_banked: RTL

PSUM_GLB_BANKED -- requirements
Module: psum_glb_banked

---
 rtl/psum_glb_banked.sv | 94 +++++++++
 1 files changed

// File: rtl/psum_glb_banked.sv
// Banked partial-sum buffer: one write/accumulate port with a one-stage commit
// pipeline and forwarding, one read port that stalls when an accumulate needs the same bank.
module psum_glb_banked #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 193600,
    parameter int NUM_BANKS  = 4,
    parameter bit SATURATE   = 1'b1,
    parameter int ADDR       = $clog2(DEPTH)
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  we_a,
    input  logic                  acc_a,
    input  logic [ADDR-1:0]       addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  re_b,
    input  logic [ADDR-1:0]       addr_b,
    output logic                  stall_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  rvalid_b
);
    localparam int BANK_BITS  = $clog2(NUM_BANKS);
    localparam int BANK_DEPTH = (DEPTH + NUM_BANKS - 1) / NUM_BANKS;
    localparam int ROW_BITS   = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam logic [ADDR:0] DEPTH_L = (ADDR+1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][BANK_DEPTH];

    logic [BANK_BITS-1:0]  bank_a, bank_b, s1_bank;
    logic [ROW_BITS-1:0]   row_a, row_b, s1_row;
    logic                  in_range_a, in_range_b;
    logic                  s1_valid, s1_acc;
    logic [ADDR-1:0]       s1_addr;
    logic [DATA_WIDTH-1:0] s1_wdata, s1_old, s1_result, acc_sum;
    logic [DATA_WIDTH:0]   sum_ext;
    logic                  fwd, rd_accept;

    // Low address bits pick the bank so consecutive words spread across banks.
    assign bank_a  = addr_a[BANK_BITS-1:0];
    assign bank_b  = addr_b[BANK_BITS-1:0];
    assign s1_bank = s1_addr[BANK_BITS-1:0];
    assign row_a   = addr_a[BANK_BITS +: ROW_BITS];
    assign row_b   = addr_b[BANK_BITS +: ROW_BITS];
    assign s1_row  = s1_addr[BANK_BITS +: ROW_BITS];

    assign in_range_a = {1'b0, addr_a} < DEPTH_L;
    assign in_range_b = {1'b0, addr_b} < DEPTH_L;

    assign sum_ext = {s1_old[DATA_WIDTH-1], s1_old} + {s1_wdata[DATA_WIDTH-1], s1_wdata};

    always_comb begin
        acc_sum = sum_ext[DATA_WIDTH-1:0];
        if (SATURATE && (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]))
            acc_sum = sum_ext[DATA_WIDTH] ? MIN_NEG : MAX_POS;
    end

    assign s1_result = s1_acc ? acc_sum : s1_wdata;

    // s1_valid is only set for in-range addresses, so it also qualifies forwarding.
    assign fwd       = s1_valid && (s1_addr == addr_a);
    assign stall_b   = !reset && re_b && we_a && acc_a && (bank_b == bank_a);
    assign rd_accept = re_b && !stall_b;

    always_ff @(posedge core_clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_b  <= '0;
        end else begin
            s1_valid <= we_a && in_range_a;
            rvalid_b <= rd_accept;
            if (rd_accept)
                rdata_b <= in_range_b ? mem[bank_b][row_b] : '0;
        end
    end

    always_ff @(posedge core_clk) begin
        if (we_a) begin
            s1_acc   <= acc_a;
            s1_addr  <= addr_a;
            s1_wdata <= wdata_a;
            s1_old   <= fwd ? s1_result : mem[bank_a][row_a];
        end
    end

    // Contents survive reset; only the in-flight commit is dropped.
    always_ff @(posedge core_clk) begin
        if (s1_valid && !reset)
            mem[s1_bank][s1_row] <= s1_result;
    end

endmodule
